// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared opcodes, limits and types for the data-memory arbiter
package dmem_arb_pkg;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {CPU = 1'b0, DMA = 1'b1} port_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: CPU-priority winner select with a DMA anti-starvation counter
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  arb,
  input  logic  cpu_req,
  input  logic  dma_req,
  output port_t winner
);
  logic [STARVE_W-1:0] starve_cnt;
  logic starved;
  assign starved = starve_cnt == STARVE_W'(STARVE_LIMIT);
  assign winner = (dma_req && (!cpu_req || starved)) ? DMA : CPU;
  // counts CPU grants that left a waiting DMA behind; any other arbitration outcome clears it
  always_ff @(posedge clock)
    if (!resetn) starve_cnt <= '0;
    else if (arb) starve_cnt <= (!dma_req || winner == DMA) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU and DMA load/store requests onto the single-ported data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic [5:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [5:0]  dma_op,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic [5:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_t state;
  port_t winner, port;
  logic [5:0] op, req_op;
  logic [31:0] addr, wdata, req_addr, req_wdata;
  logic ok;
  dmem_arb_pick u_pick (
    .clock   (clock),
    .resetn  (resetn),
    .arb     (state == IDLE),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .winner  (winner)
  );
  assign req_op = winner == DMA ? dma_op : cpu_op;
  assign req_addr = winner == DMA ? dma_addr : cpu_addr;
  assign req_wdata = winner == DMA ? dma_wdata : cpu_wdata;
  assign ok = (req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] == 2'b00;
  // resetn gates mem_op combinationally so a reset landing in ACCESS cannot commit a store
  assign mem_op = (resetn && state == ACCESS) ? op : OP_NOP;
  assign mem_addr = addr;
  assign mem_wdata = wdata;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      port <= CPU;
      op <= OP_NOP;
      addr <= '0;
      wdata <= '0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_err <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: if (cpu_req || dma_req) begin
          port <= winner;
          op <= req_op;
          addr <= req_addr;
          wdata <= req_wdata;
          state <= ok ? ACCESS : DONE;
          cpu_ack <= !ok && winner == CPU;
          cpu_err <= !ok && winner == CPU;
          dma_ack <= !ok && winner == DMA;
          dma_err <= !ok && winner == DMA;
        end
        ACCESS: begin
          state <= DONE;
          cpu_ack <= port == CPU;
          dma_ack <= port == DMA;
          if (op == OP_LW && port == CPU) cpu_rdata <= mem_rdata;
          if (op == OP_LW && port == DMA) dma_rdata <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It accepts load/store requests from the CPU pipeline port and a DMA/loader port and serialises them into one memory access at a time. It drives the memory's op/address/write-data inputs and returns read data with a one-cycle acknowledge. Misaligned or non-memory opcodes are rejected with an error flag and never reach the memory.

## Interface
- OP_LW, 6'h23: MIPS load-word opcode.
- OP_SW, 6'h2b: MIPS store-word opcode.
- STARVE_LIMIT, 4: maximum consecutive CPU grants while DMA waits (≥1).
- clock  in  1  sole clock, all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU request; held with cpu_op/addr/wdata stable until cpu_ack.
- cpu_op  in  6  opcode (OP_LW or OP_SW).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack: request rejected.
- cpu_rdata  out  32  load data, valid with cpu_ack, held until next CPU ack.
- dma_req, dma_op, dma_addr, dma_wdata, dma_ack, dma_err, dma_rdata: identical set for the DMA port.
- mem_op  out  6  opcode to memory; 6'h00 when idle.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  32  store data to memory.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, pick winner, latch its op/addr/wdata and port id. Go to ACCESS if op ∈ {OP_LW, OP_SW} and addr[1:0]==0. Otherwise set err and go to DONE. No req: stay.
- Arbitration: CPU has fixed priority. If dma_req is high and starve_cnt == STARVE_LIMIT, DMA wins.
- starve_cnt:
  - +1 on each CPU grant while dma_req is high (saturates).
  - Cleared on DMA grant.
  - Cleared at any IDLE arbitration with dma_req low.
- ACCESS: mem_op/mem_addr/mem_wdata driven from latched values. Memory performs SW at the closing edge. For LW, mem_rdata is captured into the winning port's rdata register at that edge. Go to DONE.
- DONE: winning port's ack = 1 (err as latched). Go to IDLE. The losing port's req is ignored until IDLE.
- A req still high in the cycle after ack is a new request.
- Errors do not touch rdata, mem_op or starve_cnt increments. Error grants still count as grants for the starvation rule.
- mem_op = 6'h00 outside ACCESS. mem_op is also combinationally forced to 6'h00 whenever resetn = 0, so reset during ACCESS suppresses the write.

## Timing
- Reset values: state IDLE, cpu_ack/dma_ack/cpu_err/dma_err = 0, cpu_rdata/dma_rdata = 0, mem_op = 0, mem_addr/mem_wdata = 0, starve_cnt = 0.
- Valid access latency: req sampled in IDLE at edge k → ACCESS in cycle k+1 → ack high in cycle k+2.
- Rejected request latency: ack+err in cycle k+1.
- Throughput: one valid access per 3 cycles, one rejected request per 2 cycles.
- Simultaneous cpu_req and dma_req: CPU wins unless starve_cnt == STARVE_LIMIT.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. The in-flight request is dropped without ack; the requester must reissue.
- ack and err are registered outputs. rdata changes only at the edge entering DONE.

## Structure
- Package dmem_arb_pkg: OP_LW, OP_SW, OP_NOP (6'h00) constants; state enum {IDLE, ACCESS, DONE}; port-id type (CPU=0, DMA=1).
- One sub-module, dmem_arb_pick: combinational winner select plus the starve_cnt register. The top level holds the FSM, latches and per-port response registers.

## Test plan
- CPU SW addr 0x10 data 0xDEADBEEF, then CPU LW addr 0x10 → ack 2 cycles after each req edge; cpu_rdata = 0xDEADBEEF, cpu_err = 0.
- cpu_req and dma_req high together, both LW → CPU served first; DMA ack 3 cycles later. mem_op = 6'h23 exactly in the two ACCESS cycles.
- CPU re-requests continuously with dma_req held, STARVE_LIMIT = 4 → DMA granted after exactly 4 CPU acks. starve_cnt returns to 0.
- CPU LW addr 0x13, then op 6'h00 → cpu_ack+cpu_err 1 cycle after req. mem_op stays 6'h00; cpu_rdata unchanged.
- DMA SW addr 0x20 data 0x12345678, resetn low during ACCESS → mem_op = 0 in that cycle, location 0x20 unchanged, no dma_ack. All outputs at reset values the next cycle.
- Idle bus, no req for 10 cycles → mem_op = 0 and no acks throughout.
